// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the single write port of register_file between two write-back
// requesters (A: ALU path, B: load/multi-cycle path) with round-robin
// arbitration. After reset (or a soft_init pulse) it first sweeps x1..x31
// to zero so that no architectural register is ever read as X.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   soft_init  one-cycle pulse in RUN: restart the zero sweep
//   a_valid    requester A has a write-back pending
//   a_ready    A is accepted this cycle when a_valid is high
//   a_rd       A destination register
//   a_data     A write data
//   b_valid / b_ready / b_rd / b_data   same as A for requester B
//   rf_we      register_file.we
//   rf_waddr   register_file.waddr
//   rf_wdata   register_file.wdata
//   init_done  high while in RUN
module regfile_wb_arbiter #(
  parameter int XLEN    = 32,
  parameter bit INIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            soft_init,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t ST_RESET = INIT_EN ? ST_INIT : ST_RUN;
  localparam logic   RR_A     = 1'b0;
  localparam logic   RR_B     = 1'b1;
  localparam logic [4:0] IDX_FIRST = 5'd1;
  localparam logic [4:0] IDX_LAST  = 5'd31;

  state_t          state, state_nxt;
  logic            rr, rr_nxt;
  logic [4:0]      idx, idx_nxt;
  logic            we_nxt;
  logic [4:0]      waddr_nxt;
  logic [XLEN-1:0] wdata_nxt;
  logic            done_nxt;

  logic            run;
  logic            soft_eff;
  logic            a_acc;
  logic            b_acc;

  assign run = (state == ST_RUN);

  // soft_init has no meaning when there is no sweep to re-run.
  assign soft_eff = soft_init & INIT_EN;

  // Each ready depends only on the *other* requester's valid, so a
  // requester can never combinationally loop valid -> ready -> valid.
  // The two terms are mutually exclusive when both are valid, which
  // guarantees at most one accept per cycle.
  assign a_ready = run & ~soft_eff & ~(b_valid & (rr == RR_B));
  assign b_ready = run & ~soft_eff & ~(a_valid & (rr == RR_A));

  assign a_acc = a_valid & a_ready;
  assign b_acc = b_valid & b_ready;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    idx_nxt   = idx;
    we_nxt    = 1'b0;
    waddr_nxt = rf_waddr;
    wdata_nxt = rf_wdata;
    done_nxt  = init_done;

    case (state)
      ST_INIT: begin
        we_nxt    = 1'b1;
        waddr_nxt = idx;
        wdata_nxt = '0;
        if (idx == IDX_LAST) begin
          state_nxt = ST_RUN;
          done_nxt  = 1'b1;
          idx_nxt   = IDX_FIRST;
        end else begin
          idx_nxt = idx + 5'd1;
        end
      end

      ST_RUN: begin
        if (soft_eff) begin
          state_nxt = ST_INIT;
          done_nxt  = 1'b0;
          idx_nxt   = IDX_FIRST;
        end else if (a_acc) begin
          // A write to x0 is consumed but leaves the port idle.
          we_nxt    = (a_rd != 5'd0);
          waddr_nxt = a_rd;
          wdata_nxt = a_data;
          rr_nxt    = RR_B;
        end else if (b_acc) begin
          we_nxt    = (b_rd != 5'd0);
          waddr_nxt = b_rd;
          wdata_nxt = b_data;
          rr_nxt    = RR_A;
        end
      end

      default: begin
        state_nxt = ST_RESET;
      end
    endcase
  end

  // Write-port register stage: everything visible to register_file is
  // registered here, one edge after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      rr        <= RR_A;
      idx       <= IDX_FIRST;
      rf_we     <= 1'b0;
      rf_waddr  <= 5'd0;
      rf_wdata  <= '0;
      init_done <= ~INIT_EN;
    end else begin
      state     <= state_nxt;
      rr        <= rr_nxt;
      idx       <= idx_nxt;
      rf_we     <= we_nxt;
      rf_waddr  <= waddr_nxt;
      rf_wdata  <= wdata_nxt;
      init_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        soft_init;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        init_done;

  regfile_wb_arbiter #(.XLEN(32), .INIT_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .soft_init (soft_init),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem [32];
  int          ntests = 0;
  int          nfail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_sweep(input int last);
    wr_t w;
    for (int i = 1; i <= last; i++) begin
      w.addr = 5'(i);
      w.data = 32'h0;
      exp_q.push_back(w);
    end
  endtask

  task automatic push_wr(input logic [4:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Downstream register_file model: captures the port one edge after
  // the arbiter drives it.
  always @(posedge clk) begin
    if (rf_we) mem[rf_waddr] <= rf_wdata;
  end

  // Scoreboard monitor: every write presented on the port is matched
  // against the next expected write.
  always @(negedge clk) begin
    wr_t w;
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", {27'd0, rf_waddr}, {27'd0, w.addr});
        chk("wr_data", rf_wdata, w.data);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; soft_init = 1'b0;
    a_valid = 1'b0; a_rd = 5'd0; a_data = 32'h0;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[5] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);

    // 1. reset sweep
    push_sweep(31);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("sweep_init_done", {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
      if (i < 31) chk("sweep_b_ready", {31'd0, b_ready}, 32'd0);
    end
    chk("sweep_x5", mem[5], 32'h0);

    // 2. single requester A (rr = A)
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h12345678;
    push_wr(5'd1, 32'h12345678);
    #1 chk("single_a_ready", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
    chk("single_we", {31'd0, rf_we}, 32'd1);
    chk("single_waddr", {27'd0, rf_waddr}, 32'd1);
    tick();
    chk("single_x1", mem[1], 32'h12345678);

    // 4. x0 write from B (rr = B now)
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFFFFFF;
    #1 chk("x0_b_ready", {31'd0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    chk("x0_we", {31'd0, rf_we}, 32'd0);
    tick();
    chk("x0_reads_zero", mem[0], 32'h0);

    // 3. contention, rr = A
    a_valid = 1'b1; a_rd = 5'd2; a_data = 32'hDEADBEEF;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'hCAFEF00D;
    push_wr(5'd2, 32'hDEADBEEF);
    push_wr(5'd4, 32'hCAFEF00D);
    push_wr(5'd3, 32'h00000001);
    push_wr(5'd6, 32'h00000002);
    #1;
    chk("cont1_a_ready", {31'd0, a_ready}, 32'd1);
    chk("cont1_b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    a_rd = 5'd3; a_data = 32'h1;
    #1;
    chk("cont2_a_ready", {31'd0, a_ready}, 32'd0);
    chk("cont2_b_ready", {31'd0, b_ready}, 32'd1);
    tick();
    b_rd = 5'd6; b_data = 32'h2;
    #1;
    chk("cont3_a_ready", {31'd0, a_ready}, 32'd1);
    chk("cont3_b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    #1 chk("cont4_b_ready", {31'd0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    tick();
    tick();
    chk("cont_x2", mem[2], 32'hDEADBEEF);
    chk("cont_x3", mem[3], 32'h00000001);
    chk("cont_x4", mem[4], 32'hCAFEF00D);
    chk("cont_x6", mem[6], 32'h00000002);

    // 5. soft_init collides with a valid A request
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'hA5A5A5A5;
    soft_init = 1'b1;
    push_sweep(31);
    push_wr(5'd7, 32'hA5A5A5A5);
    #1 chk("soft_a_ready", {31'd0, a_ready}, 32'd0);
    tick();
    soft_init = 1'b0;
    chk("soft_init_done_fall", {31'd0, init_done}, 32'd0);
    chk("soft_we_idle", {31'd0, rf_we}, 32'd0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("soft_init_done", {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
      chk("soft_a_ready_sweep", {31'd0, a_ready}, (i == 31) ? 32'd1 : 32'd0);
    end
    tick();
    a_valid = 1'b0;
    chk("soft_a_we", {31'd0, rf_we}, 32'd1);
    chk("soft_a_waddr", {27'd0, rf_waddr}, 32'd7);
    tick();
    chk("soft_x7", mem[7], 32'hA5A5A5A5);

    // 6. asynchronous reset at sweep index 17
    soft_init = 1'b1;
    push_sweep(16);
    tick();
    soft_init = 1'b0;
    for (int i = 1; i <= 16; i++) tick();
    chk("midrst_waddr_before", {27'd0, rf_waddr}, 32'd16);
    #5 rst_n = 1'b0;
    #1;
    chk("midrst_we", {31'd0, rf_we}, 32'd0);
    chk("midrst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("midrst_init_done", {31'd0, init_done}, 32'd0);
    push_sweep(31);
    #9 rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("midrst_sweep_done", {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
    end
    tick();
    tick();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
